multicycle_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I datapath (decode, regfile, ALU, memories).

---
 rtl/multicycle_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer for an RV32I datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the memory
// request handshakes and the IR/PC/regfile strobes, counts retired
// instructions and traps on an illegal opcode or a memory timeout.
// Handshake: a request (o_imem_req / o_dmem_req) is held high every cycle the
// sequencer waits; the cycle in which the matching ack is high completes the
// transfer. Acks seen in any other state have no effect.
module multicycle_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [6:0]       i_opcode,
  input  logic             i_br_taken,
  input  logic             i_imem_ack,
  input  logic             i_dmem_ack,
  output logic             o_imem_req,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic [1:0]       o_pc_sel,
  output logic             o_rf_we,
  output logic [1:0]       o_wb_sel,
  output logic [2:0]       o_state,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_retired
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             legal, is_b, is_ld, is_st, is_jal, is_jalr;
  logic             tmo_last;
  logic [2:0]       boundary;

  // Opcode classification from the latched IR.
  always_comb begin
    is_b    = (i_opcode == OP_B);
    is_ld   = (i_opcode == OP_LOAD);
    is_st   = (i_opcode == OP_S);
    is_jal  = (i_opcode == OP_JAL);
    is_jalr = (i_opcode == OP_JALR);
    legal   = (i_opcode == OP_R) || (i_opcode == OP_I) || is_ld || is_st ||
              is_b || is_jal || is_jalr || (i_opcode == OP_LUI) ||
              (i_opcode == OP_AUIPC);
    // tmo_q counts completed wait cycles, so this is the MEM_TIMEOUT-th request cycle.
    tmo_last = (tmo_q == TW'(MEM_TIMEOUT - 1));
    // i_run is only sampled at an instruction boundary.
    boundary = i_run ? S_FETCH : S_IDLE;
  end

  // Next-state, strobe and select decode.
  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    retire     = 1'b0;
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_ir_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 2'd0;
    o_rf_we    = 1'b0;
    o_wb_sel   = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (i_run) state_d = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_we = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_last) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        if (is_b) begin
          o_pc_we  = 1'b1;
          o_pc_sel = {1'b0, i_br_taken};
          retire   = 1'b1;
          state_d  = boundary;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = is_st;
        if (i_dmem_ack) begin
          if (is_st) begin
            o_pc_we = 1'b1;
            retire  = 1'b1;
            state_d = boundary;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_last) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd3;
        end
      end
      S_WB: begin
        o_rf_we  = 1'b1;
        o_pc_we  = 1'b1;
        o_wb_sel = is_ld ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        o_pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        retire   = 1'b1;
        state_d  = boundary;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Wait counter runs only while staying in a request state; any entry clears it.
    if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q)) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = '0;
    end
    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  // State, timeout, trap and retire-count registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // Status outputs straight from registers.
  always_comb begin
    o_state      = state_q;
    o_trap       = trap_q;
    o_trap_cause = cause_q;
    o_retired    = retired_q;
  end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Testbench for multicycle_seq_ctrl: directed instruction table, hand-written
// corner sequences and random instruction streams, all checked cycle by cycle
// against an expected trace built from the instruction-level rules.
module tb_multicycle_seq_ctrl;

  localparam int T  = 16;
  localparam int CW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          run, br, iack, dack;
  logic [6:0]    op;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, trap;
  logic [1:0]    pc_sel, wb_sel, cause;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_seq_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_opcode(op), .i_br_taken(br),
    .i_imem_ack(iack), .i_dmem_ack(dack),
    .o_imem_req(imem_req), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_ir_we(ir_we), .o_pc_we(pc_we), .o_pc_sel(pc_sel), .o_rf_we(rf_we),
    .o_wb_sel(wb_sel), .o_state(state), .o_trap(trap), .o_trap_cause(cause),
    .o_retired(retired)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // one cycle of stimulus plus the outputs expected in that cycle
  typedef struct {
    logic run; logic [6:0] op; logic br; logic iack; logic dack;
    logic [2:0] st; logic ireq; logic dreq; logic dwe; logic irwe; logic pcwe;
    logic [1:0] pcsel; logic rfwe; logic [1:0] wbsel; logic trap; logic [1:0] cause;
    logic [CW-1:0] ret;
  } rec_t;

  // directed instruction: inputs and literal expectations
  typedef struct {
    logic [6:0] op; logic br; int iw; int dw; logic run_after;
    int exp_lat; logic [1:0] exp_pcsel; logic [1:0] exp_wbsel;
  } dir_t;

  rec_t plan[$];
  int   m_ret;
  bit   m_idle;
  bit   m_trapped;

  logic [6:0] legal_ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic [6:0] bad_ops[4]   = '{7'h7F, 7'h00, 7'h0B, 7'h5B};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t blank(input logic [2:0] st, input logic [6:0] o);
    rec_t r;
    r.run = 1'($urandom_range(0, 1)); r.op = o; r.br = 1'($urandom_range(0, 1));
    r.iack = 1'($urandom_range(0, 1)); r.dack = 1'($urandom_range(0, 1));
    r.st = st; r.ireq = 0; r.dreq = 0; r.dwe = 0; r.irwe = 0; r.pcwe = 0;
    r.pcsel = 0; r.rfwe = 0; r.wbsel = 0; r.trap = 0; r.cause = 0;
    r.ret = CW'(m_ret);
    return r;
  endfunction

  task automatic push_trap(input logic [1:0] c, input logic [6:0] o);
    rec_t r;
    for (int k = 0; k < 20; k++) begin
      r = blank(3'd7, o); r.trap = 1; r.cause = c; plan.push_back(r);
    end
    m_trapped = 1;
  endtask

  task automatic push_retire(input rec_t r, input logic run_after);
    r.run = run_after;
    plan.push_back(r);
    m_ret  = (m_ret + 1) % (1 << CW);
    m_idle = !run_after;
  endtask

  // expected trace for one instruction, derived from the instruction rules
  task automatic build_instr(input logic [6:0] o, input logic b, input int iw,
                             input int dw, input logic run_after);
    rec_t r;
    bit is_b, is_ld, is_st, is_jal, is_jalr, legal;
    is_b = (o == 7'h63); is_ld = (o == 7'h03); is_st = (o == 7'h23);
    is_jal = (o == 7'h6F); is_jalr = (o == 7'h67);
    legal = 0;
    foreach (legal_ops[j]) if (legal_ops[j] == o) legal = 1;
    plan.delete();
    if (m_idle) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        r = blank(3'd0, o); r.run = 0; plan.push_back(r);
      end
      r = blank(3'd0, o); r.run = 1; plan.push_back(r);
    end
    for (int k = 0; k < T; k++) begin
      r = blank(3'd1, o); r.ireq = 1; r.iack = (k == iw); r.irwe = r.iack;
      plan.push_back(r);
      if (k == iw) break;
    end
    if (iw >= T) begin push_trap(2'd2, o); return; end
    r = blank(3'd2, o); plan.push_back(r);
    if (!legal) begin push_trap(2'd1, o); return; end
    r = blank(3'd3, o);
    if (is_b) begin
      r.br = b; r.pcwe = 1; r.pcsel = {1'b0, b};
      push_retire(r, run_after); return;
    end
    plan.push_back(r);
    if (is_ld || is_st) begin
      for (int k = 0; k < T; k++) begin
        r = blank(3'd4, o); r.dreq = 1; r.dwe = is_st; r.dack = (k == dw);
        if ((k == dw) && is_st) begin
          r.pcwe = 1; push_retire(r, run_after); return;
        end
        plan.push_back(r);
        if (k == dw) break;
      end
      if (dw >= T) begin push_trap(2'd3, o); return; end
    end
    r = blank(3'd5, o); r.rfwe = 1; r.pcwe = 1;
    r.wbsel = is_ld ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
    r.pcsel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
    push_retire(r, run_after);
  endtask

  // driver + cycle compare; entered and left at posedge+1
  task automatic apply_plan(output int lat, output logic [1:0] rpc,
                            output logic [1:0] rwb, output int ireq_cnt);
    rec_t r;
    int first;
    bit bad;
    first = -1; lat = -1; rpc = 2'bxx; rwb = 2'bxx; ireq_cnt = 0;
    for (int i = 0; i < plan.size(); i++) begin
      r = plan[i];
      run = r.run; op = r.op; br = r.br; iack = r.iack; dack = r.dack;
      @(negedge clk);
      if ((state == 3'd1) && (first < 0)) first = i;
      if (imem_req) ireq_cnt++;
      if (pc_we && (first >= 0) && (lat < 0)) begin
        lat = i - first + 1; rpc = pc_sel; rwb = wb_sel;
      end
      bad = (state !== r.st) || (imem_req !== r.ireq) || (dmem_req !== r.dreq) ||
            (dmem_we !== r.dwe) || (ir_we !== r.irwe) || (pc_we !== r.pcwe) ||
            (pc_sel !== r.pcsel) || (rf_we !== r.rfwe) || (wb_sel !== r.wbsel) ||
            (trap !== r.trap) || (cause !== r.cause) || (retired !== r.ret);
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL trace[%0d] op=%h st/ireq/dreq/dwe/irwe/pcwe/pcsel/rfwe/wbsel/trap/cause/ret got %0d/%b/%b/%b/%b/%b/%0d/%b/%0d/%b/%0d/%0d expected %0d/%b/%b/%b/%b/%b/%0d/%b/%0d/%b/%0d/%0d",
                 i, r.op, state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                 wb_sel, trap, cause, retired, r.st, r.ireq, r.dreq, r.dwe, r.irwe,
                 r.pcwe, r.pcsel, r.rfwe, r.wbsel, r.trap, r.cause, r.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; run = 0; iack = 0; dack = 0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_strobes", {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, pc_sel, wb_sel}, 32'd0);
    chk("reset_trap", {trap, cause}, 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    m_ret = 0; m_idle = 1; m_trapped = 0;
  endtask

  initial begin
    dir_t dir[12];
    int lat, icnt;
    logic [1:0] rpc, rwb;
    logic [6:0] rop;
    int riw, rdw;

    dir[0]  = '{7'h13, 1'b0, 0,  0,  1'b1, 4,  2'd0, 2'd0};
    dir[1]  = '{7'h63, 1'b1, 0,  0,  1'b1, 3,  2'd1, 2'd0};
    dir[2]  = '{7'h63, 1'b0, 0,  0,  1'b1, 3,  2'd0, 2'd0};
    dir[3]  = '{7'h03, 1'b0, 0,  3,  1'b1, 8,  2'd0, 2'd1};
    dir[4]  = '{7'h23, 1'b0, 0,  0,  1'b1, 4,  2'd0, 2'd0};
    dir[5]  = '{7'h6F, 1'b0, 0,  0,  1'b0, 4,  2'd1, 2'd2};
    dir[6]  = '{7'h67, 1'b0, 0,  0,  1'b1, 4,  2'd2, 2'd2};
    dir[7]  = '{7'h37, 1'b0, 0,  0,  1'b1, 4,  2'd0, 2'd0};
    dir[8]  = '{7'h17, 1'b0, 0,  0,  1'b0, 4,  2'd0, 2'd0};
    dir[9]  = '{7'h33, 1'b0, 15, 0,  1'b1, 19, 2'd0, 2'd0};
    dir[10] = '{7'h03, 1'b0, 0,  15, 1'b0, 20, 2'd0, 2'd1};
    dir[11] = '{7'h23, 1'b0, 2,  1,  1'b1, 7,  2'd0, 2'd0};

    rst = 1; run = 0; op = 7'h13; br = 0; iack = 0; dack = 0;
    #12;
    chk("por_state", 32'(state), 32'd0);
    chk("por_trap", {trap, cause}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    m_ret = 0; m_idle = 1; m_trapped = 0;

    // directed table
    for (int i = 0; i < 12; i++) begin
      build_instr(dir[i].op, dir[i].br, dir[i].iw, dir[i].dw, dir[i].run_after);
      apply_plan(lat, rpc, rwb, icnt);
      chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(dir[i].exp_lat));
      chk($sformatf("dir%0d_pc_sel", i), 32'(rpc), 32'(dir[i].exp_pcsel));
      chk($sformatf("dir%0d_wb_sel", i), 32'(rwb), 32'(dir[i].exp_wbsel));
    end
    chk("dir_retired_total", 32'(retired), 32'd12);

    // illegal opcode: trap held, then reset clears it
    build_instr(7'h7F, 1'b0, 0, 0, 1'b1);
    apply_plan(lat, rpc, rwb, icnt);
    chk("illegal_cause", 32'(cause), 32'd1);
    do_reset();

    // fetch timeout after exactly T request cycles
    build_instr(7'h13, 1'b0, T, 0, 1'b1);
    apply_plan(lat, rpc, rwb, icnt);
    chk("imem_timeout_req_cycles", 32'(icnt), 32'(T));
    chk("imem_timeout_cause", 32'(cause), 32'd2);
    do_reset();

    // data timeout
    build_instr(7'h03, 1'b0, 0, T, 1'b1);
    apply_plan(lat, rpc, rwb, icnt);
    chk("dmem_timeout_cause", 32'(cause), 32'd3);
    do_reset();

    // reset mid-request drops the request at once; a late ack is ignored
    run = 1; iack = 0; op = 7'h13;
    @(posedge clk); #1;
    chk("midreq_req_up", 32'(imem_req), 32'd1);
    #2 rst = 1;
    #1;
    chk("midreq_req_dropped", {29'd0, state}, 32'd0);
    chk("midreq_req_low", 32'(imem_req), 32'd0);
    iack = 1; run = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("late_ack_ignored", {state, ir_we}, 32'd0);
    iack = 0;
    m_ret = 0; m_idle = 1; m_trapped = 0;

    // counter wrap: 17 retires on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      build_instr(7'h13, 1'b0, 0, 0, 1'b1);
      apply_plan(lat, rpc, rwb, icnt);
    end
    chk("retired_wrap", 32'(retired), 32'd1);
    do_reset();

    // random instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 19) == 0) rop = bad_ops[$urandom_range(0, 3)];
      else rop = legal_ops[$urandom_range(0, 8)];
      riw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 2);
      rdw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 2);
      build_instr(rop, 1'($urandom_range(0, 1)), riw, rdw, 1'($urandom_range(0, 1)));
      apply_plan(lat, rpc, rwb, icnt);
      if (m_trapped) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
